// File: rtl/lfsr_intlv_pkg.sv
// Shared constants, FSM encoding and LFSR step for the LFSR interleaver
// frame buffer (read and write address sequencers).
package lfsr_intlv_pkg;

  localparam int ADDR_W = 14;
  localparam int N_MAX  = 12282;

  // taps at bits 13, 4, 2, 0 for x^14+x^5+x^3+x+1
  localparam logic [ADDR_W-1:0] TAP_MASK = 14'h2015;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] lfsr_next(
    input logic [ADDR_W-1:0] s
  );
    return {s[ADDR_W-2:0], ^(s & TAP_MASK)};
  endfunction

  // the all-zero state would lock the LFSR, so it maps to 1
  function automatic logic [ADDR_W-1:0] seed_fix(
    input logic [ADDR_W-1:0] s
  );
    return (s == '0) ? ADDR_W'(1) : s;
  endfunction

endpackage

// File: rtl/lfsr14_step.sv
// One combinational LFSR step: next state, in-range flag and the
// address (s-1) that an accepted state maps to.
module lfsr14_step
  import lfsr_intlv_pkg::*;
(
  input  logic [ADDR_W-1:0] s,
  output logic [ADDR_W-1:0] nxt,
  output logic              acc,
  output logic [ADDR_W-1:0] addr
);

  assign nxt  = lfsr_next(s);
  assign acc  = (s <= ADDR_W'(N_MAX + 1));
  assign addr = s - ADDR_W'(1);

endmodule

// File: rtl/lfsr_deint_reader.sv
// Read-side permuted address sequencer; DEINT_LOOKAHEAD_EN evaluates two
// LFSR steps per free cycle so bubbles only occur on double rejections.
module lfsr_deint_reader
  import lfsr_intlv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] seed,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] s1, a0;
  logic              acc0;
  logic              emit;
  logic [ADDR_W-1:0] emit_addr;
  logic [ADDR_W-1:0] adv;
  logic              hs;
  logic              slot_free;
  logic              last_q;

  lfsr14_step u_step0 (
    .s    (lfsr_q),
    .nxt  (s1),
    .acc  (acc0),
    .addr (a0)
  );

`ifdef DEINT_LOOKAHEAD_EN
  logic [ADDR_W-1:0] s2, a1;
  logic              acc1;

  lfsr14_step u_step1 (
    .s    (s1),
    .nxt  (s2),
    .acc  (acc1),
    .addr (a1)
  );

  // a double rejection still consumes both states
  always_comb begin
    emit      = acc0 | acc1;
    emit_addr = acc0 ? a0 : a1;
    adv       = acc0 ? s1 : s2;
  end
`else
  assign emit      = acc0;
  assign emit_addr = a0;
  assign adv       = s1;
`endif

  assign hs        = rd_valid_q & rd_ready;
  assign slot_free = ~rd_valid_q | rd_ready;
  assign last_q    = rd_valid_q & (count_q == ADDR_W'(N_MAX));

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = rd_valid_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      rd_valid_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            lfsr_d  = seed_fix(seed);
            count_d = '0;
            busy_d  = 1'b1;
          end
        end
        ST_RUN: begin
          if (hs) begin
            count_d = count_q + ADDR_W'(1);
          end
          if (hs && last_q) begin
            state_d    = ST_DONE;
            rd_valid_d = 1'b0;
            done_d     = 1'b1;
          end else if (slot_free) begin
            rd_valid_d = emit;
            lfsr_d     = adv;
            if (emit) begin
              rd_addr_d = emit_addr;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d    = ST_IDLE;
          rd_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= ADDR_W'(1);
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_lfsr_deint_reader.sv
// Randomized bench for lfsr_deint_reader against a queue-based model
// of the accepted LFSR states.
module tb_lfsr_deint_reader;

  localparam int N = 12283;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rd_ready = 1'b0;
  logic [13:0] seed = '0;
  logic [13:0] rd_addr;
  logic [13:0] count;
  logic        rd_valid, rd_last, busy, done;

  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];
  bit seen[N];
  int first_cyc;
  int first_addr;
  int f5[5];

  always #5 clk = ~clk;

  lfsr_deint_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .seed     (seed),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_next(input int s);
    int fb;
    fb = ((s >> 13) ^ (s >> 4) ^ (s >> 2) ^ s) & 1;
    return ((s << 1) & 16383) | fb;
  endfunction

  // expected read order: every LFSR state in 1..N, minus one, in visit order
  task automatic build(input int sd);
    int s;
    exp_q.delete();
    s = (sd == 0) ? 1 : sd;
    for (int k = 0; k < 16383 && exp_q.size() < N; k++) begin
      if (s >= 1 && s <= N) exp_q.push_back(s - 1);
      s = ref_next(s);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_last"}, rd_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  // mode bit0: random backpressure incl. a 5-cycle stall; bit1: start pulses while busy
  task automatic run_frame(input string tag, input logic [13:0] sd,
                           input int mode, input int stop);
    int idx, cyc, bad, early, missing;
    int hold;
    bit held, pv, prdy, pl, rdy;
    logic [13:0] pa;
    idx = 0; cyc = 0; bad = 0; early = 0; missing = 0;
    hold = 0; held = 0; pv = 0; prdy = 0; pl = 0; pa = '0;
    build(int'(sd));
    foreach (seen[i]) seen[i] = 0;
    first_cyc = -1;
    first_addr = -1;
    foreach (f5[i]) f5[i] = -1;
    @(negedge clk);
    seed = sd;
    start = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_cnt0"}, count, 0);
    while (idx < N && cyc < 40000 && !(stop > 0 && idx >= stop)) begin
      if (cyc >= 1 && cyc <= 5) f5[cyc-1] = rd_valid ? int'(rd_addr) : -1;
      if (done) early++;
      if (int'(count) != idx) bad++;
      if (rd_last !== (rd_valid && idx == N - 1)) bad++;
      if (pv && !prdy) begin
        if (!rd_valid || rd_addr != pa || rd_last != pl) bad++;
      end
      if (rd_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_addr = int'(rd_addr);
        end
        if (int'(rd_addr) != exp_q[idx]) bad++;
      end
      if (mode & 1) begin
        if (!held && idx == 50 && rd_valid) begin
          hold = 5;
          held = 1;
        end
        if (hold > 0) begin
          rdy = 0;
          hold--;
        end else begin
          rdy = ($urandom_range(0, 7) != 0);
        end
      end else begin
        rdy = 1;
      end
      rd_ready = rdy;
      start = ((mode & 2) != 0) && ($urandom_range(0, 499) == 0);
      if (start) seed = 14'($urandom);
      if (rd_valid && rdy) begin
        if (int'(rd_addr) >= N || seen[rd_addr]) bad++;
        else seen[rd_addr] = 1;
        idx++;
      end
      pv = rd_valid; prdy = rdy; pa = rd_addr; pl = rd_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_seq_errs"}, bad, 0);
    chk({tag, "_early_done"}, early, 0);
    if (stop > 0) begin
      chk({tag, "_reached"}, idx, stop);
    end else begin
      foreach (seen[i]) if (!seen[i]) missing++;
      chk({tag, "_handshakes"}, idx, N);
      chk({tag, "_missing"}, missing, 0);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_done_cnt"}, count, N);
      chk({tag, "_done_busy"}, busy, 1);
      chk({tag, "_done_valid"}, rd_valid, 0);
      @(negedge clk);
      chk({tag, "_done_off"}, done, 0);
      chk({tag, "_busy_off"}, busy, 0);
    end
  endtask

  initial begin
    int want5[5];
    int w;
    want5 = '{0, 2, 6, 13, 28};
    #1 rst_n = 1'b0;
    #1 chk_reset("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame("seed1", 14'd1, 0, 0);
    chk("seed1_first_cyc", first_cyc, 1);
    for (int i = 0; i < 5; i++) chk("seed1_first5", f5[i], want5[i]);

    run_frame("seed0_bp", 14'd0, 1, 0);

    run_frame("abort", 14'($urandom), 0, 100);
    w = 0;
    while (!rd_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("abort_valid_pre", rd_valid, 1);
    chk("abort_cnt_pre", count, 100);
    rd_ready = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", rd_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", count, 100);
    @(negedge clk);
    chk("abort_done2", done, 0);

    run_frame("restart", 14'($urandom), 2, 0);

    run_frame("midrst", 14'($urandom), 1, 500);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame("s3fff", 14'h3FFF, 0, 0);
    chk("s3fff_bubble", (first_cyc >= 2), 1);
    chk("s3fff_first_ok", (first_addr >= 0 && first_addr < N), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_deint_reader.md
# lfsr_deint_reader

- Read-side address sequencer for the LFSR-based interleaver frame buffer.
- The write side stores a frame of N_MAX+1 symbols in linear order.
- This block regenerates the same 14-bit maximal-length LFSR sequence and rejects (skips) out-of-range states. It streams a permuted read-address sequence covering every address 0..N_MAX exactly once, with a valid/ready handshake toward the RAM read port.

## Interface
- ADDR_W, 14, LFSR and address width
- N_MAX, 12282, highest legal address; frame length is N_MAX+1 = 12283
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start pulse; ignored while busy
- seed  in  ADDR_W  LFSR seed, sampled on accepted start
- abort  in  1  terminates the frame immediately
- rd_addr  out  ADDR_W  read address
- rd_valid  out  1  rd_addr valid
- rd_ready  in  1  RAM side accepts rd_addr
- rd_last  out  1  qualifies the final address of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last handshake
- count  out  ADDR_W  addresses handshaken so far in the current frame

## Operation
- The single clock is clk. Reset rst_n is asynchronous and active-low.
- LFSR: Fibonacci, polynomial x^14+x^5+x^3+x+1.
  - fb = s[13]^s[4]^s[2]^s[0]
  - next = {s[12:0], fb}
  - The LFSR never holds 0. A seed of 0 is replaced by 1.
- Acceptance: state s is accepted iff s <= N_MAX+1. The emitted address is s-1, 14-bit unsigned, so it is never negative.
- FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN on start. On that transition: lfsr <= sanitized seed, count <= 0, busy <= 1.
  - RUN, on a cycle where the output slot is free (!rd_valid || rd_ready):
    - If the current state is accepted: load rd_addr, assert rd_valid, and advance the LFSR one step.
    - If it is rejected: advance one step and produce no output (bubble).
  - count increments on every handshake (rd_valid && rd_ready).
  - rd_last = rd_valid && (count == N_MAX).
  - The handshake with rd_last moves RUN -> DONE. DONE asserts done for one cycle, then returns to IDLE with busy = 0.
- abort in any state: next state IDLE, rd_valid = 0, busy = 0, no done pulse. abort takes priority over start and over a simultaneous handshake, so count is not incremented.
- start while busy is ignored.
- Backpressure: while rd_valid && !rd_ready, rd_addr and rd_last stay stable and the LFSR does not advance.
- A full frame takes at most 16383 LFSR steps. Coverage is guaranteed for any seed because the LFSR is maximal-length.

## Timing
- Reset values: rd_addr = 0, rd_valid = 0, rd_last = 0, busy = 0, done = 0, count = 0, lfsr = 1, state = IDLE.
- start sampled at edge T: busy = 1 after T. The first rd_valid appears after T+1 at the earliest, if the seed is accepted. Each rejected state adds one bubble cycle.
- With continuous rd_ready and no rejections, throughput is one address per cycle.
- done is asserted in the cycle after the final handshake. busy drops together with done.
- Reset mid-frame returns all outputs to their reset values asynchronously. No partial frame resumes.

## Configuration
- DEINT_LOOKAHEAD_EN
  - Defined: each free cycle evaluates both s and next(s). It emits the first accepted one and advances 1 or 2 steps. A bubble occurs only if both are rejected; in that case the LFSR advances 2 steps.
  - Undefined: one step per cycle as described above.
- The emitted address sequence, rd_last, done and count are identical in both builds. Only bubble cycles differ.

## Structure
- Package lfsr_intlv_pkg holds:
  - ADDR_W and N_MAX defaults
  - the tap mask constant
  - the FSM state enum
  - a function lfsr_next(s)
- The write-side address logic uses lfsr_intlv_pkg too.
- One natural sub-module, lfsr14_step: combinational next-state and accept flag. It is instantiated once, or twice chained under DEINT_LOOKAHEAD_EN.

## Test plan
- Basic sequence: seed = 1, rd_ready held 1 -> first five rd_addr are 0, 2, 6, 13, 28 on consecutive cycles starting 2 cycles after start.
- Full frame coverage: seed = 1, rd_ready held 1 -> exactly 12283 handshakes, every address 0..12282 exactly once, no address > 12282, rd_last only on the 12283rd, one done pulse the cycle after, count = 12283 at done.
- Seed handling: seed = 0 -> output sequence identical to seed = 1. Seed = 14'h3FFF -> the rejected state yields a bubble, the first emitted address is < 12283, and full coverage still holds. Check in both builds.
- Backpressure: rd_ready = 0 for 5 cycles with rd_valid high -> rd_addr and rd_last stable, count unchanged, sequence unchanged afterwards.
- Abort and start collisions: abort at count = 100 -> rd_valid = 0 and busy = 0 next cycle, no done. A new start then restarts from the new seed with count = 0. start while busy -> no effect on the sequence.
- Reset mid-frame: rst_n low asynchronously at count = 500 -> all outputs return to reset values immediately. A later start produces a full correct frame.
